// File: rtl/serial_unloader.sv
// Parallel-in, serial-out unloader with valid/ready handshake, LSB first.
// Optional macro SERIAL_PARITY_EN appends an even-parity bit after the data bits.
module serial_unloader #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  input  logic [size-1:0] inputData,
  input  logic            serReady,
  output logic            serOut,
  output logic            serValid,
  output logic            busy,
  output logic            done
);

`ifdef SERIAL_PARITY_EN
  localparam int NBITS = size + 1;
`else
  localparam int NBITS = size;
`endif
  localparam int CW = $clog2(size + 2);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [size-1:0] shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cur_bit;

`ifdef SERIAL_PARITY_EN
  logic parity_q, parity_d;

  // Data bits are exhausted once the counter reaches size; send the captured parity then.
  assign cur_bit = (cnt_q == CW'(size)) ? parity_q : shreg_q[0];

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`else
  assign cur_bit = shreg_q[0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_PARITY_EN
    parity_d = parity_q;
`endif
    serOut   = 1'b0;
    serValid = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (ld) begin
          shreg_d  = inputData;
          cnt_d    = '0;
`ifdef SERIAL_PARITY_EN
          parity_d = ^inputData;
`endif
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        serValid = 1'b1;
        serOut   = cur_bit;
        if (serReady) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule
